// File: rtl/muller_c_pkg.sv
// Shared constants and the clocked C-element next-state rule used by every
// control stage of the micropipeline.
package muller_c_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int MAX_IN    = 8;

  // Bits at or above n are ignored; inv flips an input before the
  // all-ones / all-zeros test.
  function automatic logic c_next(input logic [MAX_IN-1:0] ins,
                                  input logic [MAX_IN-1:0] inv,
                                  input int                n,
                                  input logic              cur);
    logic all1;
    logic all0;
    logic v;
    all1 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < MAX_IN; i++) begin
      if (i < n) begin
        v    = ins[i] ^ inv[i];
        all1 = all1 & v;
        all0 = all0 & ~v;
      end
    end
    if (all1) return 1'b1;
    if (all0) return 1'b0;
    return cur;
  endfunction

endpackage

// File: rtl/muller_c_cell.sv
// One registered C-element: output follows the (optionally inverted) inputs
// when they all agree, otherwise it keeps its previous value.
module muller_c_cell
  import muller_c_pkg::*;
#(
  parameter int              N_IN = 2,
  parameter logic [N_IN-1:0] INV  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] ins,
  output logic            c_q
);

  logic [MAX_IN-1:0] ins_x;
  logic [MAX_IN-1:0] inv_x;

  assign ins_x = MAX_IN'(ins);
  assign inv_x = MAX_IN'(INV);

  always_ff @(posedge clk) begin
    if (rst) c_q <= 1'b0;
    else     c_q <= c_next(ins_x, inv_x, N_IN, c_q);
  end

endmodule

// File: rtl/muller_c_pipe.sv
// Clocked four-phase micropipeline: DEPTH C-element stages with bundled data
// latches, handshake counters and a sticky protocol-violation flag.
module muller_c_pipe
  import muller_c_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_req,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ack,
  output logic             out_req,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ack,
  output logic [CNT_W-1:0] in_cnt,
  output logic [CNT_W-1:0] out_cnt,
  output logic             proto_err
);

  logic [DEPTH-1:0] c;
  logic [DEPTH-1:0] left;
  logic [DEPTH-1:0] right;
  logic [DEPTH-1:0] rise;
  logic [WIDTH-1:0] d [DEPTH];
  logic             in_req_q;
  logic             out_ack_q;

  // Each stage sees its predecessor and the inverted successor.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign left[i] = in_req;
    end else begin : g_mid_l
      assign left[i] = c[i-1];
    end
    if (i == DEPTH - 1) begin : g_last
      assign right[i] = out_ack;
    end else begin : g_mid_r
      assign right[i] = c[i+1];
    end

    assign rise[i] = ~c[i] & left[i] & ~right[i];

    muller_c_cell #(
      .N_IN (2),
      .INV  (2'b10)
    ) u_cell (
      .clk (wb_clk_i),
      .rst (wb_rst_i),
      .ins ({right[i], left[i]}),
      .c_q (c[i])
    );
  end

  // A stage captures its predecessor's data on the same edge its control rises,
  // so the data is valid in the first cycle the control reads 1.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      if (rise[0]) d[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (rise[i]) d[i] <= d[i-1];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      proto_err <= 1'b0;
      in_req_q  <= 1'b0;
      out_ack_q <= 1'b0;
    end else begin
      in_req_q  <= in_req;
      out_ack_q <= out_ack;
      if (rise[0]) in_cnt <= in_cnt + 1'b1;
      if (out_ack && !out_ack_q && c[DEPTH-1]) out_cnt <= out_cnt + 1'b1;
      // Withdrawn request or spurious acknowledge; sticky until reset.
      if ((in_req_q && !in_req && !c[0]) || (!out_ack_q && out_ack && !c[DEPTH-1]))
        proto_err <= 1'b1;
    end
  end

  assign in_ack   = c[0];
  assign out_req  = c[DEPTH-1];
  assign out_data = d[DEPTH-1];

endmodule

// File: tb/tb_muller_c_pipe.sv
// Bench for muller_c_pipe: handshake driver tasks on both ends, a token
// queue as the ordering reference and handshake tallies as the counter model.
module tb_muller_c_pipe;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_req;
  logic [WIDTH-1:0] in_data;
  logic             in_ack;
  logic             out_req;
  logic [WIDTH-1:0] out_data;
  logic             out_ack;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic             proto_err;

  int checks   = 0;
  int failures = 0;
  int m_in;
  int m_out;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  muller_c_pipe #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .in_req    (in_req),
    .in_data   (in_data),
    .in_ack    (in_ack),
    .out_req   (out_req),
    .out_data  (out_data),
    .out_ack   (out_ack),
    .in_cnt    (in_cnt),
    .out_cnt   (out_cnt),
    .proto_err (proto_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_req = 1'b0; out_ack = 1'b0; in_data = '0;
    step(); step();
    rst = 1'b0;
    m_in = 0; m_out = 0;
    exp_q.delete();
  endtask

  // Producer side of one four-phase handshake, bounded waits.
  task automatic send(input logic [WIDTH-1:0] v, input int gap);
    int n;
    in_data = v; in_req = 1'b1; n = 0;
    while (!in_ack && n < 100) begin step(); n++; end
    checks++;
    if (in_ack !== 1'b1) begin
      failures++; $display("FAIL send_ack data=%02h in_ack=%b want 1", v, in_ack);
      in_req = 1'b0; return;
    end
    m_in++; exp_q.push_back(v);
    in_req = 1'b0; n = 0;
    while (in_ack && n < 100) begin step(); n++; end
    checks++;
    if (in_ack !== 1'b0) begin
      failures++; $display("FAIL send_release in_ack=%b want 0", in_ack); return;
    end
    repeat (gap) step();
  endtask

  // Consumer side: check the delivered token, then acknowledge after gap edges.
  task automatic recv(input int gap);
    int n;
    logic [WIDTH-1:0] want;
    n = 0;
    while (!out_req && n < 200) begin step(); n++; end
    checks++;
    if (out_req !== 1'b1) begin
      failures++; $display("FAIL recv_req out_req=%b want 1", out_req); return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL recv_extra got=%02h want none", out_data); return;
    end
    want = exp_q.pop_front();
    if (out_data !== want) begin
      failures++; $display("FAIL recv_data got=%02h want %02h", out_data, want);
    end
    repeat (gap) step();
    out_ack = 1'b1; n = 0;
    while (out_req && n < 100) begin step(); n++; end
    out_ack = 1'b0;
    m_out++;
    checks++;
    if (out_req !== 1'b0) begin
      failures++; $display("FAIL recv_release out_req=%b want 0", out_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_req = 1'b1; out_ack = 1'b0; in_data = 8'hFF;
    step();
    checks++;
    if ({in_ack, out_req, out_data, in_cnt, out_cnt, proto_err} !== '0) begin
      failures++;
      $display("FAIL reset_state ack=%b req=%b data=%02h ic=%0d oc=%0d err=%b want all 0",
               in_ack, out_req, out_data, in_cnt, out_cnt, proto_err);
    end
    do_reset();
  endtask

  task automatic test_single_token();
    do_reset();
    in_data = 8'hA5; in_req = 1'b1;
    step();
    checks++;
    if (in_ack !== 1'b1 || in_cnt !== 1) begin
      failures++; $display("FAIL single_ack in_ack=%b in_cnt=%0d want 1 1", in_ack, in_cnt);
    end
    step(); step();
    checks++;
    if (out_req !== 1'b0) begin
      failures++; $display("FAIL single_early out_req=%b want 0 after edge 3", out_req);
    end
    step();
    checks++;
    if (out_req !== 1'b1 || out_data !== 8'hA5) begin
      failures++; $display("FAIL single_out out_req=%b data=%02h want 1 a5", out_req, out_data);
    end
  endtask

  task automatic test_fill();
    int n;
    bit acked;
    logic [WIDTH-1:0] want;
    do_reset();
    send(8'hA5, 0);
    send(8'h3C, 0);
    repeat (4) step();
    checks++;
    if (in_cnt !== CNT_W'(m_in) || m_in != 2) begin
      failures++; $display("FAIL fill_in_cnt got=%0d want 2", in_cnt);
    end
    in_data = 8'h77; in_req = 1'b1; acked = 1'b0;
    for (int i = 0; i < 8; i++) begin step(); if (in_ack) acked = 1'b1; end
    checks++;
    if (acked !== 1'b0) begin
      failures++; $display("FAIL fill_full_ack in_ack seen=%b want 0", acked);
    end
    want = exp_q.pop_front();
    checks++;
    if (out_req !== 1'b1 || out_data !== want) begin
      failures++; $display("FAIL fill_head req=%b data=%02h want 1 %02h", out_req, out_data, want);
    end
    out_ack = 1'b1; n = 0;
    while (out_req && n < 50) begin step(); n++; end
    out_ack = 1'b0; m_out++;
    checks++;
    if (out_cnt !== CNT_W'(m_out)) begin
      failures++; $display("FAIL fill_out_cnt got=%0d want %0d", out_cnt, m_out);
    end
    n = 0;
    while (!in_ack && n < 50) begin step(); n++; end
    checks++;
    if (in_ack !== 1'b1) begin
      failures++; $display("FAIL fill_reack in_ack=%b want 1", in_ack);
    end
    m_in++; exp_q.push_back(8'h77); in_req = 1'b0;
    recv(0);
    recv(0);
  endtask

  task automatic test_stream();
    do_reset();
    fork
      for (int i = 0; i < 20; i++) send(WIDTH'(i), 0);
      for (int i = 0; i < 20; i++) recv(0);
    join
    repeat (3) step();
    checks++;
    if (in_cnt !== CNT_W'(m_in) || out_cnt !== CNT_W'(m_out) || proto_err !== 1'b0
        || exp_q.size() != 0) begin
      failures++;
      $display("FAIL stream_end ic=%0d oc=%0d err=%b left=%0d want %0d %0d 0 0",
               in_cnt, out_cnt, proto_err, exp_q.size(), CNT_W'(m_in), CNT_W'(m_out));
    end
  endtask

  task automatic test_random();
    do_reset();
    fork
      for (int i = 0; i < 30; i++) send(WIDTH'($urandom), $urandom_range(0, 3));
      for (int i = 0; i < 30; i++) recv($urandom_range(0, 3));
    join
    repeat (3) step();
    checks++;
    if (in_cnt !== CNT_W'(m_in) || out_cnt !== CNT_W'(m_out) || proto_err !== 1'b0) begin
      failures++;
      $display("FAIL random_end ic=%0d oc=%0d err=%b want %0d %0d 0",
               in_cnt, out_cnt, proto_err, CNT_W'(m_in), CNT_W'(m_out));
    end
  endtask

  task automatic test_proto_errors();
    do_reset();
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    checks++;
    if (proto_err !== 1'b1 || out_cnt !== 0) begin
      failures++; $display("FAIL proto_ack err=%b oc=%0d want 1 0", proto_err, out_cnt);
    end
    repeat (5) step();
    checks++;
    if (proto_err !== 1'b1) begin
      failures++; $display("FAIL proto_sticky err=%b want 1", proto_err);
    end
    do_reset();
    send(8'h11, 0);
    send(8'h22, 0);
    in_data = 8'h33; in_req = 1'b1;
    repeat (3) step();
    checks++;
    if (proto_err !== 1'b0) begin
      failures++; $display("FAIL proto_clean err=%b want 0", proto_err);
    end
    in_req = 1'b0;
    step();
    checks++;
    if (proto_err !== 1'b1) begin
      failures++; $display("FAIL proto_withdraw err=%b want 1", proto_err);
    end
  endtask

  task automatic test_reset_midflight();
    int n;
    bit ack1;
    do_reset();
    send(8'hC3, 0);
    send(8'h5A, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({in_ack, out_req, out_data, in_cnt, out_cnt} !== '0) begin
      failures++;
      $display("FAIL midreset ack=%b req=%b data=%02h ic=%0d oc=%0d want all 0",
               in_ack, out_req, out_data, in_cnt, out_cnt);
    end
    in_data = 8'h96; in_req = 1'b1; n = 0; ack1 = 1'b0;
    do begin
      step(); n++;
      if (n == 1) ack1 = in_ack;
    end while (!out_req && n < 20);
    checks++;
    if (n != DEPTH || ack1 !== 1'b1 || out_data !== 8'h96) begin
      failures++;
      $display("FAIL midreset_latency edges=%0d ack1=%b data=%02h want %0d 1 96",
               n, ack1, out_data, DEPTH);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    fork
      for (int i = 0; i < 17; i++) send(WIDTH'($urandom), 0);
      for (int i = 0; i < 17; i++) recv(0);
    join
    repeat (3) step();
    checks++;
    if (in_cnt !== CNT_W'(m_in) || out_cnt !== CNT_W'(m_out) || m_in != 17) begin
      failures++;
      $display("FAIL wrap ic=%0d oc=%0d want %0d %0d", in_cnt, out_cnt,
               CNT_W'(m_in), CNT_W'(m_out));
    end
  endtask

  initial begin
    test_reset();
    test_single_token();
    test_fill();
    test_stream();
    test_random();
    test_proto_errors();
    test_reset_midflight();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
